// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler: filters taken-branch updates from two units,
// queues them, and drains one entry per cycle into the BTB update port.
module btb_update_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            a_valid,
  input  logic            a_branch,
  input  logic            a_taken,
  input  logic [XLEN-1:0] a_PC,
  input  logic [XLEN-1:0] a_target_PC,
  input  logic            b_valid,
  input  logic            b_branch,
  input  logic            b_taken,
  input  logic [XLEN-1:0] b_PC,
  input  logic [XLEN-1:0] b_target_PC,
  input  logic            btb_hold,
  output logic            upd_ready,
  output logic            btb_wr_valid,
  output logic [XLEN-1:0] btb_wr_PC,
  output logic [XLEN-1:0] btb_wr_target_PC,
  output logic            overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_pc [FIFO_DEPTH];
  logic [XLEN-1:0] mem_tg [FIFO_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          qa;
  logic          qb;
  logic          fa;
  logic          pop;
  logic [CW-1:0] free;
  logic          acc_a;
  logic          acc_b;
  logic          drop;
  logic [1:0]    push_n;
  logic [PW-1:0] b_slot;

  assign qa = a_valid & a_branch & a_taken;
  assign qb = b_valid & b_branch & b_taken;

  // B supersedes A when both hit the same PC: B is younger.
  assign fa = qa & ~(qb & (a_PC == b_PC));

  // Reset gating keeps the BTB from writing on the reset edge.
  assign pop = (count != '0) & ~btb_hold & reset;

  // A slot freed by this edge's pop is usable by this edge's push.
  assign free = CW'(FIFO_DEPTH) - count + CW'(pop);

  // B claims a slot first, A gets whatever remains.
  assign acc_b  = qb & (free != '0);
  assign acc_a  = fa & (free > CW'(acc_b));
  assign drop   = (qb & ~acc_b) | (fa & ~acc_a);
  assign push_n = {1'b0, acc_a} + {1'b0, acc_b};
  assign b_slot = acc_a ? tail + PW'(1) : tail;

  assign btb_wr_valid     = pop;
  assign btb_wr_PC        = mem_pc[head];
  assign btb_wr_target_PC = mem_tg[head];
  assign upd_ready        = count <= CW'(FIFO_DEPTH - 2);

  // Pointer, occupancy and sticky-overflow state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage; contents survive reset, A lands before B.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (acc_a) begin
        mem_pc[tail] <= a_PC;
        mem_tg[tail] <= a_target_PC;
      end
      if (acc_b) begin
        mem_pc[b_slot] <= b_PC;
        mem_tg[b_slot] <= b_target_PC;
      end
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: queue-based reference model
// compared every cycle, plus literal expectations per scenario.
module tb_btb_update_ctrl;

  localparam int D = 4;
  localparam int X = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         a_valid, a_branch, a_taken;
  logic [X-1:0] a_PC, a_target_PC;
  logic         b_valid, b_branch, b_taken;
  logic [X-1:0] b_PC, b_target_PC;
  logic         btb_hold;
  logic         upd_ready;
  logic         btb_wr_valid;
  logic [X-1:0] btb_wr_PC, btb_wr_target_PC;
  logic         overflow;

  btb_update_ctrl #(.FIFO_DEPTH(D), .XLEN(X)) dut (
    .clock(clock),
    .reset(reset),
    .a_valid(a_valid),
    .a_branch(a_branch),
    .a_taken(a_taken),
    .a_PC(a_PC),
    .a_target_PC(a_target_PC),
    .b_valid(b_valid),
    .b_branch(b_branch),
    .b_taken(b_taken),
    .b_PC(b_PC),
    .b_target_PC(b_target_PC),
    .btb_hold(btb_hold),
    .upd_ready(upd_ready),
    .btb_wr_valid(btb_wr_valid),
    .btb_wr_PC(btb_wr_PC),
    .btb_wr_target_PC(btb_wr_target_PC),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [X-1:0] pc;
    logic [X-1:0] tg;
  } ent_t;

  ent_t mq[$];
  ent_t wlog[$];
  bit   movf;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: drive, compare against model, advance model at the edge.
  task automatic cyc(input bit rst, input bit hold,
                     input bit av, input bit at,
                     input logic [X-1:0] ap, input logic [X-1:0] atg,
                     input bit bv,
                     input logic [X-1:0] bp, input logic [X-1:0] btg);
    bit pop, qa, qb, fa, ka, kb;
    int free;
    reset = rst; btb_hold = hold;
    a_valid = av; a_branch = 1'b1; a_taken = at;
    a_PC = ap; a_target_PC = atg;
    b_valid = bv; b_branch = 1'b1; b_taken = 1'b1;
    b_PC = bp; b_target_PC = btg;
    #1;
    pop = (mq.size() != 0) && !hold && rst;
    chk("wr_valid", 64'(btb_wr_valid), 64'(pop));
    if (pop) begin
      chk("wr_pc", 64'(btb_wr_PC), 64'(mq[0].pc));
      chk("wr_tg", 64'(btb_wr_target_PC), 64'(mq[0].tg));
    end
    chk("upd_ready", 64'(upd_ready), 64'((D - mq.size()) >= 2));
    chk("overflow", 64'(overflow), 64'(movf));
    if (btb_wr_valid === 1'b1)
      wlog.push_back('{btb_wr_PC, btb_wr_target_PC});
    @(posedge clock);
    if (!rst) begin
      mq.delete();
      movf = 0;
    end else begin
      qa = av && at;
      qb = bv;
      fa = qa && !(qb && ap == bp);
      free = D - mq.size() + int'(pop);
      kb = qb && free >= 1;
      ka = fa && (free - int'(kb)) >= 1;
      if ((qb && !kb) || (fa && !ka)) movf = 1;
      if (pop) void'(mq.pop_front());
      if (ka) mq.push_back('{ap, atg});
      if (kb) mq.push_back('{bp, btg});
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n, input bit hold);
    for (int i = 0; i < n; i++) cyc(1, hold, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pair(input bit hold, input logic [X-1:0] ap,
                      input logic [X-1:0] bp);
    cyc(1, hold, 1, 1, ap, ap + 1, 1, bp, bp + 1);
  endtask

  initial begin
    reset = 1'b0; btb_hold = 1'b0;
    a_valid = 0; a_branch = 0; a_taken = 0; a_PC = 0; a_target_PC = 0;
    b_valid = 0; b_branch = 0; b_taken = 0; b_PC = 0; b_target_PC = 0;
    movf = 0;
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_ready", 64'(upd_ready), 64'd1);
    chk("rst_valid", 64'(btb_wr_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single update
    wlog.delete();
    cyc(1, 0, 1, 1, 32'h100, 32'h200, 0, 0, 0);
    #1 chk("single_lat", 64'(btb_wr_valid), 64'd1);
    idle(3, 0);
    chk("single_n", 64'(wlog.size()), 64'd1);
    chk("single_pc", 64'(wlog[0].pc), 64'h100);
    chk("single_tg", 64'(wlog[0].tg), 64'h200);

    // dual update
    wlog.delete();
    cyc(1, 0, 1, 1, 32'h100, 32'h140, 1, 32'h180, 32'h1c0);
    idle(3, 0);
    chk("dual_n", 64'(wlog.size()), 64'd2);
    chk("dual_0", 64'(wlog[0].pc), 64'h100);
    chk("dual_1", 64'(wlog[1].pc), 64'h180);

    // A not taken
    wlog.delete();
    cyc(1, 0, 1, 0, 32'h100, 32'h140, 1, 32'h180, 32'h1c0);
    idle(3, 0);
    chk("nt_n", 64'(wlog.size()), 64'd1);
    chk("nt_pc", 64'(wlog[0].pc), 64'h180);

    // same-PC filter
    wlog.delete();
    cyc(1, 0, 1, 1, 32'h300, 32'h400, 1, 32'h300, 32'h500);
    idle(3, 0);
    chk("same_n", 64'(wlog.size()), 64'd1);
    chk("same_tg", 64'(wlog[0].tg), 64'h500);

    // hold fills the queue, then overflow with hold
    wlog.delete();
    pair(1, 32'h10, 32'h20);
    pair(1, 32'h30, 32'h40);
    idle(1, 1);
    #1;
    chk("full_ready", 64'(upd_ready), 64'd0);
    chk("full_valid", 64'(btb_wr_valid), 64'd0);
    pair(1, 32'h50, 32'h60);
    #1 chk("ovf_hold", 64'(overflow), 64'd1);
    idle(6, 0);
    chk("drain_n", 64'(wlog.size()), 64'd4);
    chk("drain_0", 64'(wlog[0].pc), 64'h10);
    chk("drain_1", 64'(wlog[1].pc), 64'h20);
    chk("drain_2", 64'(wlog[2].pc), 64'h30);
    chk("drain_3", 64'(wlog[3].pc), 64'h40);

    // overflow while popping: B kept, A dropped
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("ovf_clr", 64'(overflow), 64'd0);
    wlog.delete();
    pair(1, 32'h110, 32'h120);
    pair(1, 32'h130, 32'h140);
    pair(0, 32'h150, 32'h160);
    idle(6, 0);
    chk("pop_n", 64'(wlog.size()), 64'd5);
    chk("pop_4", 64'(wlog[4].pc), 64'h160);
    chk("pop_ovf", 64'(overflow), 64'd1);

    // reset mid-drain
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wlog.delete();
    pair(1, 32'h210, 32'h220);
    cyc(1, 1, 1, 1, 32'h230, 32'h231, 0, 0, 0);
    idle(1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rd_valid", 64'(btb_wr_valid), 64'd0);
    chk("rd_ready", 64'(upd_ready), 64'd1);
    chk("rd_ovf", 64'(overflow), 64'd0);
    idle(4, 0);
    chk("rd_n", 64'(wlog.size()), 64'd1);
    chk("rd_pc", 64'(wlog[0].pc), 64'h210);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
